ehl_fifo_wptr_ctrl: RTL



---
 rtl/ehl_fifo_wptr_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/ehl_fifo_wptr_ctrl.sv
// ehl_fifo_wptr_ctrl
// Write-side pointer controller for a dual-clock FIFO (write clock domain).
// Keeps the binary write pointer, drives the RAM write address and a
// registered Gray write pointer for the read-domain synchronizer, and
// computes a registered full flag against the synchronized Gray read pointer.
//
// Optional feature macro: EHL_FIFO_WPTR_LEVEL_EN
//   defined   : registered occupancy (level) and almost-full (afull) outputs
//   undefined : no Gray-to-binary logic, level and afull tied to 0
//
// Handshake: wr_req is a level request from the client; wr_ack is high in
// exactly the cycles an entry is taken (wr_req & ~full), combinationally,
// and doubles as the RAM write enable. A request while full is simply not
// acknowledged and has no side effect; the client holds wr_req until acked.

module ehl_fifo_wptr_ctrl #(
  parameter int ADDR  = 4,
  parameter int AFULL = (1 << ADDR) - 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            wr_req,
  output logic            wr_ack,
  input  logic [ADDR:0]   rptr_gray,
  output logic [ADDR-1:0] waddr,
  output logic [ADDR:0]   wptr_gray,
  output logic            full,
  output logic [ADDR:0]   level,
  output logic            afull
);

  // Elaboration-time sanity checks on the configuration.
  if (ADDR < 1) begin : g_bad_addr
    $error("ehl_fifo_wptr_ctrl: ADDR must be >= 1");
  end
  if (AFULL < 1 || AFULL > (1 << ADDR)) begin : g_bad_afull
    $error("ehl_fifo_wptr_ctrl: AFULL must be in 1..2**ADDR");
  end

  // Inverting the top two Gray bits of the read pointer gives the Gray code
  // of (read pointer + depth); the FIFO is full when the write pointer hits it.
  // For ADDR=1 this mask covers both bits, i.e. the whole pointer is inverted.
  localparam logic [ADDR:0] FULL_MASK = (ADDR + 1)'(3) << (ADDR - 1);

  logic [ADDR:0] wbin;
  logic [ADDR:0] wbin_next;
  logic [ADDR:0] wgray_next;
  logic          full_next;

  assign wr_ack = wr_req & ~full;
  assign waddr  = wbin[ADDR-1:0];

  // Next binary/Gray pointer and full flag; pointer arithmetic wraps mod 2^(ADDR+1).
  always_comb begin
    wbin_next  = wbin + {{ADDR{1'b0}}, wr_ack};
    wgray_next = (wbin_next >> 1) ^ wbin_next;
    full_next  = (wgray_next == (rptr_gray ^ FULL_MASK));
  end

  // Pointer and full registers; Gray pointer is registered so it never glitches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wbin      <= '0;
      wptr_gray <= '0;
      full      <= 1'b0;
    end else begin
      wbin      <= wbin_next;
      wptr_gray <= wgray_next;
      full      <= full_next;
    end
  end

`ifdef EHL_FIFO_WPTR_LEVEL_EN
  localparam logic [ADDR:0] AFULL_V = (ADDR + 1)'(AFULL);

  logic [ADDR:0] rbin;
  logic [ADDR:0] level_next;
  logic          afull_next;

  // Gray-to-binary of the read pointer as a prefix XOR from the MSB, then occupancy.
  always_comb begin
    rbin       = '0;
    rbin[ADDR] = rptr_gray[ADDR];
    for (int i = ADDR - 1; i >= 0; i--) begin
      rbin[i] = rbin[i+1] ^ rptr_gray[i];
    end
    level_next = wbin_next - rbin;
    afull_next = (level_next >= AFULL_V);
  end

  // Occupancy and almost-full registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level <= '0;
      afull <= 1'b0;
    end else begin
      level <= level_next;
      afull <= afull_next;
    end
  end
`else
  assign level = '0;
  assign afull = 1'b0;
`endif

endmodule
